// File: rtl/mw8080_input_pkg.sv
// rtl/mw8080_input_pkg.sv - scancodes, joystick bit layout and coin FSM states
package mw8080_input_pkg;

    localparam logic [7:0] KC_COIN = 8'h2E;
    localparam logic [7:0] KC_TILT = 8'h2C;

    // Element i of each table is start/direction/fire bit i.
    localparam logic [3:0][7:0] KC_START   = {8'h25, 8'h26, 8'h1E, 8'h16};
    localparam logic [3:0][7:0] KC_P0_DIR  = {8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [3:0][7:0] KC_P0_FIRE = {8'h12, 8'h29, 8'h11, 8'h14};
    localparam logic [3:0][7:0] KC_P1_DIR  = {8'h1D, 8'h1B, 8'h1C, 8'h23};
    localparam logic [3:0][7:0] KC_P1_FIRE = {8'h42, 8'h3B, 8'h33, 8'h34};

    localparam int JOY_R    = 0;
    localparam int JOY_L    = 1;
    localparam int JOY_D    = 2;
    localparam int JOY_U    = 3;
    localparam int JOY_FIRE = 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD
    } coin_st_t;

endpackage

// File: rtl/mw8080_input_ctrl_if.sv
// rtl/mw8080_input_ctrl_if.sv - keyboard event bus from user_io
interface mw8080_input_ctrl_if;
    logic       key_strobe;
    logic       key_pressed;
    logic [7:0] key_code;

    modport master (output key_strobe, key_pressed, key_code);
    modport slave  (input  key_strobe, key_pressed, key_code);
endinterface

// File: rtl/mw8080_coin_pulse.sv
// rtl/mw8080_coin_pulse.sv - fixed-length coin pulse with re-arm holdoff
module mw8080_coin_pulse
    import mw8080_input_pkg::*;
#(
    parameter logic [15:0] COIN_CYCLES    = 16'd50000,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic coin_n
);

    coin_st_t    state;
    coin_st_t    state_d;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic        src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            src_q  <= 1'b0;
            coin_n <= 1'b1;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            src_q  <= src;
            coin_n <= (state_d != PULSE);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (src && !src_q) begin
                    cnt_d   = COIN_CYCLES - 16'd1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt == 16'd0) begin
                    cnt_d   = HOLDOFF_CYCLES - 16'd1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            HOLD: begin
                // Any active source cycle restarts the inactive-gap measurement.
                if (src) begin
                    cnt_d = HOLDOFF_CYCLES - 16'd1;
                end else if (cnt == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mw8080_input_ctrl.sv
// rtl/mw8080_input_ctrl.sv - keyboard/joystick merge, rotation and registered active-low controls
module mw8080_input_ctrl
    import mw8080_input_pkg::*;
#(
    parameter int          PLAYERS        = 2,
    parameter int          BUTTONS        = 4,
    parameter logic [15:0] COIN_CYCLES    = 16'd50000,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    mw8080_input_ctrl_if.slave         key,
    input  logic [8*PLAYERS-1:0]       joystick,
    input  logic                       rotate,
    input  logic                       joyswap,
    output logic                       Coin_n,
    output logic [PLAYERS-1:0]         Start_n,
    output logic [4*PLAYERS-1:0]       Dir_n,
    output logic [BUTTONS*PLAYERS-1:0] Fire_n,
    output logic                       Tilt_n
);

    logic                  armed;
    logic                  coin_q, coin_d;
    logic                  tilt_q, tilt_d;
    logic [3:0]            start_q, start_d;
    logic [1:0][3:0]       kdir_q, kdir_d;
    logic [1:0][3:0]       kfire_q, kfire_d;
    logic [8*PLAYERS-1:0]  joy_w;
    logic [4*PLAYERS-1:0]  dir_n_d;
    logic [BUTTONS*PLAYERS-1:0] fire_n_d;
    logic                  unused_joy;

    // armed blocks the strobe sampled on the edge where reset is released.
    always_comb begin
        coin_d  = coin_q;
        tilt_d  = tilt_q;
        start_d = start_q;
        kdir_d  = kdir_q;
        kfire_d = kfire_q;
        if (armed && key.key_strobe) begin
            if (key.key_code == KC_COIN) coin_d = key.key_pressed;
            if (key.key_code == KC_TILT) tilt_d = key.key_pressed;
            for (int i = 0; i < 4; i++) begin
                if (key.key_code == KC_START[i])   start_d[i]    = key.key_pressed;
                if (key.key_code == KC_P0_DIR[i])  kdir_d[0][i]  = key.key_pressed;
                if (key.key_code == KC_P0_FIRE[i]) kfire_d[0][i] = key.key_pressed;
                if (key.key_code == KC_P1_DIR[i])  kdir_d[1][i]  = key.key_pressed;
                if (key.key_code == KC_P1_FIRE[i]) kfire_d[1][i] = key.key_pressed;
            end
        end
    end

    if (PLAYERS > 1) begin : g_swap
        always_comb begin
            joy_w = joystick;
            if (joyswap) begin
                joy_w[7:0]  = joystick[15:8];
                joy_w[15:8] = joystick[7:0];
            end
        end
    end else begin : g_noswap
        logic unused_swap;
        assign joy_w       = joystick;
        assign unused_swap = joyswap;
    end

    assign unused_joy = ^joy_w;

    always_comb begin
        logic [3:0]         kb_dir;
        logic [3:0]         kb_fire;
        logic [3:0]         raw_dir;
        logic [3:0]         rot_dir;
        logic [BUTTONS-1:0] raw_fire;
        dir_n_d  = '1;
        fire_n_d = '1;
        kb_dir   = '0;
        kb_fire  = '0;
        raw_dir  = '0;
        rot_dir  = '0;
        raw_fire = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            kb_dir   = (p == 0) ? kdir_d[0]  : ((p == 1) ? kdir_d[1]  : 4'b0000);
            kb_fire  = (p == 0) ? kfire_d[0] : ((p == 1) ? kfire_d[1] : 4'b0000);
            raw_dir  = joy_w[8*p +: 4] | kb_dir;
            raw_fire = joy_w[8*p+JOY_FIRE +: BUTTONS] | kb_fire[BUTTONS-1:0];
            rot_dir  = raw_dir;
            if (rotate) begin
                rot_dir[JOY_U] = raw_dir[JOY_L];
                rot_dir[JOY_R] = raw_dir[JOY_U];
                rot_dir[JOY_D] = raw_dir[JOY_R];
                rot_dir[JOY_L] = raw_dir[JOY_D];
            end
            if (rot_dir[JOY_U] && rot_dir[JOY_D]) begin
                rot_dir[JOY_U] = 1'b0;
                rot_dir[JOY_D] = 1'b0;
            end
            if (rot_dir[JOY_L] && rot_dir[JOY_R]) begin
                rot_dir[JOY_L] = 1'b0;
                rot_dir[JOY_R] = 1'b0;
            end
            dir_n_d[4*p +: 4]              = ~rot_dir;
            fire_n_d[BUTTONS*p +: BUTTONS] = ~raw_fire;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            armed   <= 1'b0;
            coin_q  <= 1'b0;
            tilt_q  <= 1'b0;
            start_q <= '0;
            kdir_q  <= '0;
            kfire_q <= '0;
            Start_n <= '1;
            Dir_n   <= '1;
            Fire_n  <= '1;
            Tilt_n  <= 1'b1;
        end else begin
            armed   <= 1'b1;
            coin_q  <= coin_d;
            tilt_q  <= tilt_d;
            start_q <= start_d;
            kdir_q  <= kdir_d;
            kfire_q <= kfire_d;
            Start_n <= ~start_d[PLAYERS-1:0];
            Dir_n   <= dir_n_d;
            Fire_n  <= fire_n_d;
            Tilt_n  <= ~tilt_d;
        end
    end

    mw8080_coin_pulse #(
        .COIN_CYCLES    (COIN_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_coin (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .src    (coin_d),
        .coin_n (Coin_n)
    );

endmodule

// File: tb/tb_mw8080_input_ctrl.sv
// tb/tb_mw8080_input_ctrl.sv - randomized scoreboard bench for mw8080_input_ctrl
module tb_mw8080_input_ctrl;

    localparam int P  = 2;
    localparam int B  = 2;
    localparam int CC = 4;
    localparam int HC = 3;

    localparam logic [7:0] KD [2][4] = '{'{8'h74, 8'h6B, 8'h72, 8'h75}, '{8'h23, 8'h1C, 8'h1B, 8'h1D}};
    localparam logic [7:0] KF [2][4] = '{'{8'h14, 8'h11, 8'h29, 8'h12}, '{8'h34, 8'h33, 8'h3B, 8'h42}};
    localparam int NC = 24;
    localparam logic [7:0] CODES [NC] = '{8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h16, 8'h1E, 8'h26, 8'h25,
                                          8'h2C, 8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29,
                                          8'h23, 8'h1C, 8'h1B, 8'h1D, 8'h34, 8'h33, 8'h55, 8'h00};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*P-1:0] joystick = '0;
    logic           rotate = 1'b0;
    logic           joyswap = 1'b0;
    logic           coin_n;
    logic           tilt_n;
    logic [P-1:0]   start_n;
    logic [4*P-1:0] dir_n;
    logic [B*P-1:0] fire_n;

    mw8080_input_ctrl_if kif();

    mw8080_input_ctrl #(
        .PLAYERS        (P),
        .BUTTONS        (B),
        .COIN_CYCLES    (16'(CC)),
        .HOLDOFF_CYCLES (16'(HC))
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .key      (kif),
        .joystick (joystick),
        .rotate   (rotate),
        .joyswap  (joyswap),
        .Coin_n   (coin_n),
        .Start_n  (start_n),
        .Dir_n    (dir_n),
        .Fire_n   (fire_n),
        .Tilt_n   (tilt_n)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          low_count = 0;
    int          low_before;
    logic [15:0] exp_q [$];
    logic [15:0] e_v, a_v;

    bit key_down [256];
    bit armed;
    bit holding;
    bit prev_src;
    bit release_pending;
    int pulse_rem;
    int zero_run;

    function automatic logic [15:0] model_out(input logic [15:0] joy, input bit rot, input bit swp);
        logic [7:0] w [2];
        logic [7:0] dn;
        logic [3:0] fn;
        logic [1:0] sn;
        bit r, l, d, u, orr, ol, od, ou;
        w[0] = swp ? joy[15:8] : joy[7:0];
        w[1] = swp ? joy[7:0]  : joy[15:8];
        for (int p = 0; p < 2; p++) begin
            r = w[p][0] || key_down[KD[p][0]];
            l = w[p][1] || key_down[KD[p][1]];
            d = w[p][2] || key_down[KD[p][2]];
            u = w[p][3] || key_down[KD[p][3]];
            if (rot) begin ou = l; orr = u; od = r; ol = d; end
            else     begin ou = u; orr = r; od = d; ol = l; end
            if (ou && od)  begin ou = 0; od = 0; end
            if (ol && orr) begin ol = 0; orr = 0; end
            dn[4*p+0] = !orr;
            dn[4*p+1] = !ol;
            dn[4*p+2] = !od;
            dn[4*p+3] = !ou;
            for (int b = 0; b < B; b++) fn[B*p+b] = !(w[p][4+b] || key_down[KF[p][b]]);
        end
        sn[0] = !key_down[8'h16];
        sn[1] = !key_down[8'h1E];
        return {!(pulse_rem > 0), sn, dn, fn, !key_down[8'h2C]};
    endfunction

    task automatic step(input bit stb, input bit prs, input logic [7:0] code,
                        input logic [15:0] joy, input bit rot, input bit swp);
        bit src;
        @(negedge clk);
        if (release_pending) begin
            rst_n = 1'b1;
            release_pending = 1'b0;
        end
        kif.key_strobe  = stb;
        kif.key_pressed = prs;
        kif.key_code    = code;
        joystick = joy;
        rotate   = rot;
        joyswap  = swp;
        if (stb && armed) key_down[code] = prs;
        armed = 1'b1;
        src = key_down[8'h2E];
        if (pulse_rem > 0) begin
            pulse_rem--;
            if (pulse_rem == 0) begin holding = 1; zero_run = 0; end
        end else if (holding) begin
            if (src) zero_run = 0;
            else     zero_run++;
            if (zero_run == HC) holding = 0;
        end else if (src && !prev_src) begin
            pulse_rem = CC;
        end
        prev_src = src;
        exp_q.push_back(model_out(joy, rot, swp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, joystick, rotate, joyswap);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic check_ones(input string name);
        checks++;
        if ({coin_n, start_n, dir_n, fire_n, tilt_n} !== 16'hFFFF) begin
            failures++;
            $display("FAIL %s actual=%h required=ffff", name, {coin_n, start_n, dir_n, fire_n, tilt_n});
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Asserts reset with every input active; the next step releases it.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        kif.key_strobe  = 1'b1;
        kif.key_pressed = 1'b1;
        kif.key_code    = 8'h2E;
        joystick = '1;
        rotate   = 1'b1;
        joyswap  = 1'b1;
        #1 check_ones("reset_async");
        repeat (2) begin
            @(posedge clk);
            #2 check_ones("reset_held");
        end
        key_down = '{default: 0};
        armed = 0; pulse_rem = 0; holding = 0; zero_run = 0; prev_src = 0;
        release_pending = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && coin_n === 1'b0) low_count++;
            if (exp_q.size() > 0) begin
                e_v = exp_q.pop_front();
                a_v = {coin_n, start_n, dir_n, fire_n, tilt_n};
                checks++;
                if (a_v !== e_v) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, a_v, e_v);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          stb, prs, rot, swp;
        logic [7:0]  code;
        logic [15:0] joy;

        kif.key_strobe  = 1'b0;
        kif.key_pressed = 1'b0;
        kif.key_code    = 8'h00;
        key_down = '{default: 0};

        do_reset();
        step(1, 1, 8'h2E, 16'hFFFF, 1, 1);
        step(0, 0, 8'h00, 16'h0000, 0, 0);
        idle(3);

        step(1, 1, 8'h75, 16'h0000, 0, 0);
        idle(1);
        step(1, 0, 8'h75, 16'h0000, 0, 0);
        step(1, 1, 8'h55, 16'h0000, 0, 0);
        idle(2);

        step(0, 0, 8'h00, 16'h0002, 1, 0);
        step(0, 0, 8'h00, 16'h0003, 0, 0);
        idle(1);

        step(0, 0, 8'h00, 16'h0010, 0, 1);
        drain();
        check_bit("swap_p1_fire_a", fire_n[2], 1'b0);
        step(0, 0, 8'h00, 16'h0040, 0, 1);
        step(0, 0, 8'h00, 16'h0000, 0, 0);

        low_before = low_count;
        step(1, 1, 8'h2E, 16'h0000, 0, 0);
        idle(9);
        step(1, 0, 8'h2E, 16'h0000, 0, 0);
        idle(1);
        drain();
        check_int("coin_pulse_len", low_count - low_before, CC);

        low_before = low_count;
        step(1, 1, 8'h2E, 16'h0000, 0, 0);
        idle(3);
        step(1, 0, 8'h2E, 16'h0000, 0, 0);
        idle(2);
        drain();
        check_int("coin_early_repress", low_count - low_before, 0);

        low_before = low_count;
        step(1, 1, 8'h2E, 16'h0000, 0, 0);
        idle(6);
        step(1, 0, 8'h2E, 16'h0000, 0, 0);
        idle(5);
        drain();
        check_int("coin_rearmed", low_count - low_before, CC);

        step(1, 1, 8'h2E, 16'h0000, 0, 0);
        idle(1);
        @(posedge clk);
        #3 check_bit("coin_mid_pulse", coin_n, 1'b0);
        rst_n = 1'b0;
        #1 check_bit("coin_async_reset", coin_n, 1'b1);
        do_reset();
        step(0, 0, 8'h00, 16'h0000, 0, 0);
        low_before = low_count;
        idle(6);
        drain();
        check_int("coin_after_reset", low_count - low_before, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                step(0, 0, 8'h00, 16'h0000, 0, 0);
            end
            stb  = ($urandom_range(0, 2) == 0);
            prs  = 1'($urandom_range(0, 1));
            code = CODES[$urandom_range(0, NC-1)];
            joy  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : joystick;
            rot  = ($urandom_range(0, 15) == 0) ? !rotate : rotate;
            swp  = ($urandom_range(0, 15) == 0) ? !joyswap : joyswap;
            step(stb, prs, code, joy, rot, swp);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
